bounded_updown_counter: RTL and testbench

BOUNDED_UPDOWN_COUNTER -- requirements
Module: bounded_updown_counter

---
 rtl/bounded_updown_counter.sv | 74 +++++++
 tb/tb_bounded_updown_counter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bounded_updown_counter.sv
// Up/down counter bounded by a loadable limit, with wrap-around or saturate
// behaviour at both ends and one-cycle registered end-of-range flags.
module bounded_updown_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load_en,
  input  logic [WIDTH-1:0] count_to,
  input  logic             count_inc,
  input  logic             count_dec,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] limit,
  output logic             flag_max,
  output logic             flag_min,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic inc_only;
  logic dec_only;
  logic over_limit;

  assign inc_only   = count_inc & ~count_dec;
  assign dec_only   = count_dec & ~count_inc;
  assign over_limit = (count > limit);
  assign at_max     = (count == limit);
  assign at_min     = (count == '0);

  // reset_n is active-high despite its name: 1 forces the reset state.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      count    <= '0;
      limit    <= '1;
      flag_max <= 1'b0;
      flag_min <= 1'b0;
    end else begin
      flag_max <= 1'b0;
      flag_min <= 1'b0;
      // The new limit only governs operations from the next cycle on.
      if (load_en) begin
        limit <= count_to;
      end
      if (clear) begin
        count <= '0;
      end else if (over_limit) begin
        count <= limit;
      end else if (inc_only) begin
        if (at_max) begin
          flag_max <= 1'b1;
          if (WRAP) begin
            count <= '0;
          end
        end else begin
          count <= count + ONE;
        end
      end else if (dec_only) begin
        if (at_min) begin
          flag_min <= 1'b1;
          if (WRAP) begin
            count <= limit;
          end
        end else begin
          count <= count - ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Bench for bounded_updown_counter: three instances (4-bit wrap, 4-bit saturate,
// 8-bit wrap) share stimulus and are checked every cycle against a range model.
module tb_bounded_updown_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       load_en;
  logic [7:0] count_to;
  logic       count_inc;
  logic       count_dec;

  int checks = 0;
  int errors = 0;

  logic [3:0] cnt_a, lim_a, cnt_b, lim_b;
  logic [7:0] cnt_c, lim_c;
  logic       fmax_a, fmin_a, amax_a, amin_a;
  logic       fmax_b, fmin_b, amax_b, amin_b;
  logic       fmax_c, fmin_c, amax_c, amin_c;

  logic [7:0] d_cnt [3];
  logic [7:0] d_lim [3];
  logic       d_fmax[3];
  logic       d_fmin[3];
  logic       d_amax[3];
  logic       d_amin[3];

  // clock / reset block
  always #5 clk = ~clk;

  bounded_updown_counter #(.WIDTH(4), .WRAP(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load_en(load_en),
    .count_to(count_to[3:0]), .count_inc(count_inc), .count_dec(count_dec),
    .count(cnt_a), .limit(lim_a), .flag_max(fmax_a), .flag_min(fmin_a),
    .at_max(amax_a), .at_min(amin_a));

  bounded_updown_counter #(.WIDTH(4), .WRAP(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load_en(load_en),
    .count_to(count_to[3:0]), .count_inc(count_inc), .count_dec(count_dec),
    .count(cnt_b), .limit(lim_b), .flag_max(fmax_b), .flag_min(fmin_b),
    .at_max(amax_b), .at_min(amin_b));

  bounded_updown_counter #(.WIDTH(8), .WRAP(1'b1)) dut_c (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load_en(load_en),
    .count_to(count_to), .count_inc(count_inc), .count_dec(count_dec),
    .count(cnt_c), .limit(lim_c), .flag_max(fmax_c), .flag_min(fmin_c),
    .at_max(amax_c), .at_min(amin_c));

  assign d_cnt[0] = {4'b0, cnt_a};
  assign d_cnt[1] = {4'b0, cnt_b};
  assign d_cnt[2] = cnt_c;
  assign d_lim[0] = {4'b0, lim_a};
  assign d_lim[1] = {4'b0, lim_b};
  assign d_lim[2] = lim_c;
  assign d_fmax[0] = fmax_a;
  assign d_fmax[1] = fmax_b;
  assign d_fmax[2] = fmax_c;
  assign d_fmin[0] = fmin_a;
  assign d_fmin[1] = fmin_b;
  assign d_fmin[2] = fmin_c;
  assign d_amax[0] = amax_a;
  assign d_amax[1] = amax_b;
  assign d_amax[2] = amax_c;
  assign d_amin[0] = amin_a;
  assign d_amin[1] = amin_b;
  assign d_amin[2] = amin_c;

  // Range model: count lives in 0..limit, wrap is modulo (limit+1).
  int mw[3]    = '{4, 4, 8};
  bit mwrap[3] = '{1'b1, 1'b0, 1'b1};
  int m_cnt[3] = '{0, 0, 0};
  int m_lim[3] = '{15, 15, 255};
  bit m_fmax[3];
  bit m_fmin[3];

  always @(posedge clk or posedge reset_n) begin
    int c;
    int l;
    int nc;
    bit up;
    bit dn;
    for (int i = 0; i < 3; i++) begin
      if (reset_n) begin
        m_cnt[i]  <= 0;
        m_lim[i]  <= (1 << mw[i]) - 1;
        m_fmax[i] <= 1'b0;
        m_fmin[i] <= 1'b0;
      end else begin
        c  = m_cnt[i];
        l  = m_lim[i];
        up = count_inc && !count_dec;
        dn = count_dec && !count_inc;
        nc = c;
        if (clear) nc = 0;
        else if (c > l) nc = l;
        else if (up) nc = mwrap[i] ? (c + 1) % (l + 1) : ((c < l) ? c + 1 : l);
        else if (dn) nc = mwrap[i] ? (c + l) % (l + 1) : ((c > 0) ? c - 1 : 0);
        m_cnt[i]  <= nc;
        m_fmax[i] <= !clear && (c <= l) && up && (c == l);
        m_fmin[i] <= !clear && (c <= l) && dn && (c == 0);
        if (load_en) m_lim[i] <= int'(count_to) % (1 << mw[i]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model_cnt%0d", i),  32'(d_cnt[i]),  32'(m_cnt[i]));
      check($sformatf("model_lim%0d", i),  32'(d_lim[i]),  32'(m_lim[i]));
      check($sformatf("model_fmax%0d", i), 32'(d_fmax[i]), 32'(m_fmax[i]));
      check($sformatf("model_fmin%0d", i), 32'(d_fmin[i]), 32'(m_fmin[i]));
      check($sformatf("model_amax%0d", i), 32'(d_amax[i]), 32'(m_cnt[i] == m_lim[i]));
      check($sformatf("model_amin%0d", i), 32'(d_amin[i]), 32'(m_cnt[i] == 0));
    end
  end

  // driver: apply one cycle of inputs, return just after the capturing edge
  task automatic step(input bit clr, input bit ld, input logic [7:0] to, input bit inc, input bit dec);
    @(negedge clk);
    clear     = clr;
    load_en   = ld;
    count_to  = to;
    count_inc = inc;
    count_dec = dec;
    @(posedge clk);
    #1;
  endtask

  int exp_wrap[7] = '{1, 2, 3, 4, 5, 0, 1};
  int exp_sat7[7] = '{1, 2, 3, 4, 5, 5, 5};
  int exp_sat5[5] = '{1, 2, 3, 3, 3};

  initial begin
    reset_n = 1'b1;
    clear = 1'b0; load_en = 1'b0; count_to = '0; count_inc = 1'b0; count_dec = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt8", 32'(cnt_c), 0);
    check("rst_lim8", 32'(lim_c), 255);
    check("rst_lim4", 32'(lim_a), 15);
    check("rst_flags", 32'({fmax_a, fmin_a, fmax_c, fmin_c}), 0);
    @(negedge clk);
    reset_n = 1'b0;

    // load 5, seven increments
    step(0, 1, 8'd5, 0, 0);
    check("ld5_lim", 32'(lim_a), 5);
    check("ld5_cnt", 32'(cnt_a), 0);
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 8'd0, 1, 0);
      check("wrap_cnt", 32'(cnt_a), 32'(exp_wrap[k]));
      check("wrap_fmax", 32'(fmax_a), 32'(k == 5));
      check("sat_cnt", 32'(cnt_b), 32'(exp_sat7[k]));
      check("sat_fmax", 32'(fmax_b), 32'(k >= 5));
    end

    // decrement at zero, then saturate at limit 3
    step(1, 0, 8'd0, 0, 0);
    check("clr_cnt", 32'(cnt_b), 0);
    step(0, 0, 8'd0, 0, 1);
    check("sat_dec0_cnt", 32'(cnt_b), 0);
    check("sat_dec0_fmin", 32'(fmin_b), 1);
    check("wrap_dec0_cnt", 32'(cnt_a), 5);
    step(1, 1, 8'd3, 0, 0);
    check("clr_ld_lim", 32'(lim_b), 3);
    check("clr_fmin", 32'(fmin_b), 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 8'd0, 1, 0);
      check("sat3_cnt", 32'(cnt_b), 32'(exp_sat5[k]));
      check("sat3_fmax", 32'(fmax_b), 32'(k >= 3));
    end

    // lower limit below count, then clamp
    step(1, 1, 8'd15, 0, 0);
    repeat (9) step(0, 0, 8'd0, 1, 0);
    check("cnt9", 32'(cnt_a), 9);
    step(0, 1, 8'd4, 0, 0);
    check("ld4_lim", 32'(lim_a), 4);
    check("ld4_cnt", 32'(cnt_a), 9);
    step(0, 0, 8'd0, 1, 0);
    check("clamp_cnt", 32'(cnt_a), 4);
    check("clamp_fmax", 32'(fmax_a), 0);

    // inc and dec together hold
    step(1, 1, 8'd15, 0, 0);
    repeat (6) step(0, 0, 8'd0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 8'd0, 1, 1);
      check("both_cnt", 32'(cnt_a), 6);
      check("both_flags", 32'({fmax_a, fmin_a}), 0);
    end
    step(1, 0, 8'd0, 1, 0);
    check("clr_inc_cnt", 32'(cnt_a), 0);

    // 8-bit full-range wrap
    step(1, 1, 8'hff, 0, 0);
    step(0, 0, 8'd0, 0, 1);
    check("w8_dec_cnt", 32'(cnt_c), 255);
    check("w8_dec_fmin", 32'(fmin_c), 1);
    step(0, 0, 8'd0, 1, 0);
    check("w8_inc_cnt", 32'(cnt_c), 0);
    check("w8_inc_flags", 32'({fmax_c, fmin_c}), 32'b10);
    step(0, 0, 8'd0, 0, 1);
    check("w8_dec2_cnt", 32'(cnt_c), 255);
    check("w8_dec2_flags", 32'({fmax_c, fmin_c}), 32'b01);

    // limit zero
    step(1, 1, 8'd0, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    check("l0_inc_cnt", 32'({cnt_a, cnt_b}), 0);
    check("l0_inc_fmax", 32'({fmax_a, fmax_b}), 32'b11);
    step(0, 0, 8'd0, 0, 1);
    check("l0_dec_cnt", 32'({cnt_a, cnt_b}), 0);
    check("l0_dec_flags", 32'({fmax_a, fmin_a, fmax_b, fmin_b}), 32'b0101);

    // asynchronous reset between edges while counting
    step(1, 1, 8'd15, 0, 0);
    repeat (3) step(0, 0, 8'd0, 1, 0);
    check("pre_rst_cnt", 32'(cnt_c), 3);
    #1;
    reset_n = 1'b1;
    #1;
    check("async_cnt", 32'({cnt_a, cnt_c}), 0);
    check("async_lim", 32'({lim_a, lim_c}), 32'h0fff);
    check("async_flags", 32'({fmax_a, fmin_a, fmax_c, fmin_c}), 0);
    @(posedge clk);
    #1;
    check("rst_hold_cnt", 32'(cnt_c), 0);
    @(negedge clk);
    count_inc = 1'b0;
    reset_n = 1'b0;
    step(0, 0, 8'd0, 1, 0);
    check("post_rst_cnt", 32'(cnt_c), 1);
    check("post_rst_lim", 32'(lim_c), 255);

    // short random soak against the model
    repeat (300) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    step(0, 0, 8'd0, 0, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
